// File: rtl/dm_result_dumper.sv
// Snoops data-memory writes for the end code (or a cycle-budget timeout), then reads the
// result window back from DM and streams it over valid/ready. Optional: DUMP_CYCLE_COUNT_EN.
module dm_result_dumper #(
  parameter logic [13:0] SIM_END_ADDR = 14'h3FFF,
  parameter logic [31:0] END_CODE     = 32'hFFFF_FFFF,
  parameter logic [13:0] TEST_START   = 14'h2000,
  parameter int unsigned NUM_WORDS    = 64,
  parameter int unsigned MAX_CYCLES   = 150000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dm_wen,
  input  logic [13:0] dm_waddr,
  input  logic [31:0] dm_wdata,
  output logic        rd_req,
  output logic [13:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] out_index,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {RUN, READ, WAIT, SEND, FIN} state_e;

  localparam logic [31:0] CYC_LIMIT = 32'(MAX_CYCLES - 1);
  localparam logic [15:0] LAST_DATA = 16'(NUM_WORDS - 1);
`ifdef DUMP_CYCLE_COUNT_EN
  localparam logic [15:0] TRAILER_IDX = 16'(NUM_WORDS);
`endif

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic        rd_req_q, rd_req_d;
  logic [13:0] rd_addr_q, rd_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [31:0] cycle_q, cycle_d;

  logic        end_hit;
  logic        limit_hit;
  logic [15:0] nxt_idx;

  assign end_hit   = (dm_wen == 4'hF) && (dm_waddr == SIM_END_ADDR) && (dm_wdata == END_CODE);
  assign limit_hit = (cycle_q == CYC_LIMIT);
  assign nxt_idx   = idx_q + 16'd1;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    cycle_d     = cycle_q;
    case (state_q)
      RUN: begin
        if (end_hit || limit_hit) begin
          // The counter freezes at its trigger-cycle value; timeout wins over a coincident end code.
          state_d   = READ;
          idx_d     = 16'd0;
          rd_req_d  = 1'b1;
          rd_addr_d = TEST_START;
          busy_d    = 1'b1;
          timeout_d = limit_hit;
        end else begin
          cycle_d = cycle_q + 32'd1;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d     = SEND;
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
`ifdef DUMP_CYCLE_COUNT_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (idx_q == LAST_DATA);
`endif
      end
      SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = FIN;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
`ifdef DUMP_CYCLE_COUNT_EN
          end else if (idx_q == LAST_DATA) begin
            // Trailer goes straight out of SEND without touching DM.
            idx_d      = TRAILER_IDX;
            out_data_d = cycle_q;
            out_last_d = 1'b1;
`endif
          end else begin
            state_d     = READ;
            idx_d       = nxt_idx;
            rd_req_d    = 1'b1;
            rd_addr_d   = TEST_START + nxt_idx[13:0];
            out_valid_d = 1'b0;
          end
        end else begin
          state_d = SEND;
        end
      end
      FIN: begin
        state_d = FIN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      idx_q       <= 16'd0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= 14'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cycle_q     <= cycle_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = idx_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_dm_result_dumper.sv
// Directed bench for dm_result_dumper: three instances (default, MAX_CYCLES=100, NUM_WORDS=4)
// exercised one at a time against a DM model holding 32'hA000+k at word TEST_START+k.
module tb_dm_result_dumper;

  logic        clk;
  logic [2:0]  rst_v;
  logic [3:0]  dm_wen;
  logic [13:0] dm_waddr;
  logic [31:0] dm_wdata;
  logic        out_ready;

  logic [2:0]  rd_req_v, out_valid_v, out_last_v, busy_v, done_v, timeout_v;
  logic [13:0] rd_addr_v   [3];
  logic [31:0] rd_data_v   [3];
  logic [31:0] out_data_v  [3];
  logic [31:0] cycle_v     [3];
  logic [15:0] out_index_v [3];

  int n_checks;
  int n_errors;
  int sel;

  int          got_n;
  logic [31:0] got_data [80];
  logic [15:0] got_idx  [80];
  logic        got_last [80];
  logic        stall;
  logic [48:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] dm_q;
    always_ff @(posedge clk) dm_q <= 32'hA000 + {18'd0, rd_addr_v[g] - 14'h2000};
    assign rd_data_v[g] = dm_q;

    dm_result_dumper #(
      .NUM_WORDS  (g == 2 ? 4 : 64),
      .MAX_CYCLES (g == 1 ? 100 : 150000)
    ) u_dut (
      .clk         (clk),
      .rst         (rst_v[g]),
      .dm_wen      (dm_wen),
      .dm_waddr    (dm_waddr),
      .dm_wdata    (dm_wdata),
      .rd_req      (rd_req_v[g]),
      .rd_addr     (rd_addr_v[g]),
      .rd_data     (rd_data_v[g]),
      .out_valid   (out_valid_v[g]),
      .out_ready   (out_ready),
      .out_data    (out_data_v[g]),
      .out_index   (out_index_v[g]),
      .out_last    (out_last_v[g]),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .timeout     (timeout_v[g]),
      .cycle_count (cycle_v[g])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] outs(input int i);
    return {28'd0, rd_req_v[i], rd_addr_v[i], out_valid_v[i], out_data_v[i], out_index_v[i],
            out_last_v[i], busy_v[i], done_v[i], timeout_v[i], cycle_v[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int i, input logic [31:0] c);
    int n = 0;
    while (cycle_v[i] != c && n < 5000) begin
      tick();
      n++;
    end
    check_eq("reach_cycle", cycle_v[i], c);
  endtask

  task automatic end_write();
    dm_wen   = 4'hF;
    dm_waddr = 14'h3FFF;
    dm_wdata = 32'hFFFF_FFFF;
    tick();
    dm_wen   = 4'h0;
    dm_wdata = 32'h0;
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (!done_v[i] && n < 3000) begin
      tick();
      n++;
    end
    check_eq("done_seen", done_v[i], 1);
  endtask

  task automatic check_stream(input int nd, input logic [31:0] tv, input bit tr);
    int total;
    total = nd + (tr ? 1 : 0);
    check_eq("word_count", got_n, total);
    for (int k = 0; k < nd; k++) begin
      check_eq("word_data", got_data[k], 32'hA000 + k);
      check_eq("word_index", got_idx[k], k);
      check_eq("word_last", got_last[k], (k == total - 1));
    end
    if (tr) begin
      check_eq("trailer_data", got_data[nd], tv);
      check_eq("trailer_index", got_idx[nd], nd);
      check_eq("trailer_last", got_last[nd], 1);
    end
  endtask

  // Stream monitor: records accepted words and checks hold-while-stalled.
  initial begin : mon
    got_n = 0;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst_v[sel]) begin
        got_n = 0;
        stall = 1'b0;
      end else begin
        if (stall)
          check_eq("stall_hold", {out_valid_v[sel], out_data_v[sel], out_index_v[sel], out_last_v[sel]},
                   {1'b1, held});
        if (out_valid_v[sel] && out_ready && got_n < 80) begin
          got_data[got_n] = out_data_v[sel];
          got_idx[got_n]  = out_index_v[sel];
          got_last[got_n] = out_last_v[sel];
          got_n++;
        end
        stall = out_valid_v[sel] && !out_ready;
        held  = {out_data_v[sel], out_index_v[sel], out_last_v[sel]};
      end
    end
  end

  initial begin : main
    int n;
    n_checks  = 0;
    n_errors  = 0;
    sel       = 0;
    rst_v     = 3'b111;
    dm_wen    = 4'h0;
    dm_waddr  = 14'h0;
    dm_wdata  = 32'h0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_eq("reset_outputs", outs(0), 0);

    // Normal end plus ignored partial write
    rst_v[0] = 1'b0;
    run_to(0, 100);
    dm_wen = 4'h1; dm_waddr = 14'h3FFF; dm_wdata = 32'hFFFF_FFFF;
    tick();
    dm_wen = 4'hF; dm_wdata = 32'h0;
    tick();
    dm_wen = 4'h0;
    repeat (3) tick();
    check_eq("partial_busy", busy_v[0], 0);
    check_eq("partial_count", cycle_v[0], 105);
    run_to(0, 500);
    end_write();
    check_eq("first_rd_req", rd_req_v[0], 1);
    check_eq("first_rd_addr", rd_addr_v[0], 14'h2000);
    check_eq("busy_on_trigger", busy_v[0], 1);
    wait_done(0, n);
    check_eq("dump_len", n, 192);
    check_stream(64, 32'h0, 1'b0);
    check_eq("normal_cycle", cycle_v[0], 500);
    check_eq("normal_timeout", timeout_v[0], 0);
    check_eq("normal_busy", busy_v[0], 0);

    // Backpressure
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    run_to(0, 20);
    end_write();
    n = 0;
    while (!done_v[0] && n < 3000) begin
      tick();
      n++;
      if (n % 3 == 0) out_ready = ~out_ready;
    end
    check_eq("bp_done", done_v[0], 1);
    out_ready = 1'b1;
    check_stream(64, 32'h0, 1'b0);

    // Reset during word-10 SEND
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    run_to(0, 10);
    end_write();
    n = 0;
    while (!(out_valid_v[0] && out_index_v[0] == 16'd10) && n < 500) begin
      tick();
      n++;
    end
    check_eq("reach_word10", {out_valid_v[0], out_index_v[0]}, {1'b1, 16'd10});
    rst_v[0] = 1'b1;
    #1;
    check_eq("abort_outputs", outs(0), 0);
    tick();
    check_eq("abort_outputs_edge", outs(0), 0);
    rst_v[0] = 1'b0;
    tick();
    check_eq("restart_count", cycle_v[0], 1);
    check_eq("restart_busy", busy_v[0], 0);
    end_write();
    wait_done(0, n);
    check_stream(64, 32'h0, 1'b0);
    check_eq("restart_cycle", cycle_v[0], 1);

    // Timeout with MAX_CYCLES=100
    sel = 1;
    tick();
    rst_v[1] = 1'b0;
    n = 0;
    while (!busy_v[1] && n < 300) begin
      tick();
      n++;
    end
    check_eq("to_busy", busy_v[1], 1);
    check_eq("to_cycle", cycle_v[1], 99);
    check_eq("to_flag", timeout_v[1], 1);
    wait_done(1, n);
    check_stream(64, 32'h0, 1'b0);
    check_eq("to_flag_end", timeout_v[1], 1);

    // NUM_WORDS=4, trigger at 200
    sel = 2;
    tick();
    rst_v[2] = 1'b0;
    run_to(2, 200);
    end_write();
    wait_done(2, n);
`ifdef DUMP_CYCLE_COUNT_EN
    check_stream(4, 32'd200, 1'b1);
`else
    check_stream(4, 32'd0, 1'b0);
`endif
    check_eq("small_cycle", cycle_v[2], 200);
    check_eq("small_timeout", timeout_v[2], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
